// File: rtl/multichannel_pretrigger_buffer_if.sv
// Bus bundle for multichannel_pretrigger_buffer: per-channel front-end samples
// and delay select toward the buffer, delayed words and status back out.
// Channel c occupies the c-th slice of each packed vector.
interface multichannel_pretrigger_buffer_if #(
    parameter int P_N_CHANNELS     = 4,
    parameter int P_ADC_WIDTH      = 12,
    parameter int P_DISCR_WIDTH    = 8,
    parameter int P_PRE_CONF_WIDTH = 5
);
    localparam int CH_W = P_ADC_WIDTH + P_DISCR_WIDTH + 1;

    logic [P_N_CHANNELS*P_ADC_WIDTH-1:0]   adc_in;
    logic [P_N_CHANNELS*P_DISCR_WIDTH-1:0] discr_in;
    logic [P_N_CHANNELS-1:0]               tot_in;
    logic [P_PRE_CONF_WIDTH-1:0]           size_config;
    logic [P_N_CHANNELS*CH_W-1:0]          ptb_out;
    logic                                  rdy;
    logic                                  parity_err;

    // Front end / controller side
    modport master (
        output adc_in, discr_in, tot_in, size_config,
        input  ptb_out, rdy, parity_err
    );

    // Buffer side
    modport slave (
        input  adc_in, discr_in, tot_in, size_config,
        output ptb_out, rdy, parity_err
    );
endinterface

// File: rtl/multichannel_pretrigger_buffer.sv
// multichannel_pretrigger_buffer
// Delays the {discr, adc, tot} word of every channel by D = size_config + 1
// cycles. All channels share one circular store and one write pointer so the
// delayed streams stay sample-aligned. rdy marks when ptb_out carries real
// history; ptb_out is held at zero otherwise.
// Optional feature macro: MPTB_PARITY_EN (one even-parity bit per channel word,
// checked on read, sticky parity_err). Without it parity_err is tied low.
module multichannel_pretrigger_buffer #(
    parameter int P_N_CHANNELS          = 4,
    parameter int P_ADC_WIDTH           = 12,
    parameter int P_DISCR_WIDTH         = 8,
    parameter int P_PRE_CONF_WIDTH      = 5,
    parameter int P_USE_DISTRIBUTED_RAM = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    multichannel_pretrigger_buffer_if.slave    bus
);
    localparam int CH_W   = P_ADC_WIDTH + P_DISCR_WIDTH + 1;
    localparam int AW     = P_PRE_CONF_WIDTH;
    localparam int DEPTH  = 2**AW;
    localparam int DATA_W = P_N_CHANNELS * CH_W;
`ifdef MPTB_PARITY_EN
    localparam int PAR_W  = P_N_CHANNELS;
`else
    localparam int PAR_W  = 0;
`endif
    localparam int MEM_W  = DATA_W + PAR_W;
    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     cfg_reg, cfg_next;
    logic [AW:0]       fill_cnt_reg, fill_cnt_next;
    logic              rdy_reg, rdy_next;
    logic              first_reg;
    logic [AW:0]       depth_sel;
    logic              load_cfg;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word_reg;

    // Pack each channel as {discr, adc, tot} at its slot of the store word
    for (genvar gi = 0; gi < P_N_CHANNELS; gi++) begin : g_pack
        assign wr_data[gi*CH_W +: CH_W] = {bus.discr_in[gi*P_DISCR_WIDTH +: P_DISCR_WIDTH],
                                           bus.adc_in[gi*P_ADC_WIDTH +: P_ADC_WIDTH],
                                           bus.tot_in[gi]};
    end

`ifdef MPTB_PARITY_EN
    logic [P_N_CHANNELS-1:0] wr_par;
    logic [P_N_CHANNELS-1:0] par_fail;
    logic                    parity_err_reg;

    // Even parity per channel: stored bit makes the total count of ones even
    for (genvar gi = 0; gi < P_N_CHANNELS; gi++) begin : g_par
        assign wr_par[gi]   = ^wr_data[gi*CH_W +: CH_W];
        assign par_fail[gi] = (^rd_word_reg[gi*CH_W +: CH_W]) ^ rd_word_reg[DATA_W + gi];
    end
    assign wr_word = {wr_par, wr_data};

    // Sticky error: any parity mismatch on a word read while rdy is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else if (rdy_reg && (|par_fail)) begin
            parity_err_reg <= 1'b1;
        end
    end
    assign bus.parity_err = parity_err_reg;
`else
    assign wr_word        = wr_data;
    assign bus.parity_err = 1'b0;
`endif

    // Next-state for pointer, configuration, fill count and ready flag.
    // The first edge after reset release is handled exactly like a config
    // change so that rdy only rises once D real samples sit behind the
    // read pointer (the reset edge itself never wrote anything).
    always_comb begin
        wr_ptr_next   = wr_ptr_reg + 1'b1;
        cfg_next      = cfg_reg;
        fill_cnt_next = fill_cnt_reg;
        rdy_next      = rdy_reg;
        depth_sel     = {1'b0, cfg_reg} + 1'b1;
        load_cfg      = first_reg || (bus.size_config != cfg_reg);
        if (load_cfg) begin
            // A change always wins over a simultaneous fill completion
            cfg_next      = bus.size_config;
            fill_cnt_next = '0;
            rdy_next      = 1'b0;
        end else begin
            if (fill_cnt_reg != FILL_MAX) begin
                fill_cnt_next = fill_cnt_reg + 1'b1;
            end
            if (fill_cnt_next == depth_sel) begin
                rdy_next = 1'b1;
            end
        end
    end

    // Read address is wr_ptr - (cfg + 1), which modulo the depth is wr_ptr + ~cfg.
    // With D equal to the full depth this is the slot being overwritten; the
    // read-before-write store returns the old (D-cycle-old) word.
    assign rd_addr = wr_ptr_reg + ~cfg_reg;

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            cfg_reg      <= '0;
            fill_cnt_reg <= '0;
            rdy_reg      <= 1'b0;
            first_reg    <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            cfg_reg      <= cfg_next;
            fill_cnt_reg <= fill_cnt_next;
            rdy_reg      <= rdy_next;
            first_reg    <= 1'b0;
        end
    end

    // Circular store. Writes run unconditionally: while in reset the pointer
    // sits at 0 and that slot is rewritten on the first edge after release.
    if (P_USE_DISTRIBUTED_RAM != 0) begin : g_dist
        (* ram_style = "distributed" *) logic [MEM_W-1:0] store_reg [DEPTH];

        // Write current samples, register the D-cycle-old word
        always_ff @(posedge clk) begin
            store_reg[wr_ptr_reg] <= wr_word;
            rd_word_reg           <= store_reg[rd_addr];
        end
    end else begin : g_bram
        (* ram_style = "block" *) logic [MEM_W-1:0] store_reg [DEPTH];

        // Write current samples, register the D-cycle-old word
        always_ff @(posedge clk) begin
            store_reg[wr_ptr_reg] <= wr_word;
            rd_word_reg           <= store_reg[rd_addr];
        end
    end

    // Output is zero whenever the history is not yet valid; reset clears it at once
    assign bus.ptb_out = rdy_reg ? rd_word_reg[DATA_W-1:0] : '0;
    assign bus.rdy     = rdy_reg;

endmodule
